// File: rtl/led_pattern_engine_if.sv
// Control/status bundle for led_pattern_engine: mode requests and pause in,
// LED drive, step pulse and displayed mode out.
interface led_pattern_engine_if #(
    parameter int unsigned NUM_LEDS = 4
);
    logic [1:0]          mode_sel;
    logic                mode_load;
    logic                pause;
    logic [NUM_LEDS-1:0] led;
    logic                tick;
    logic [1:0]          mode_active;

    // Controller side drives requests and observes the display.
    modport master (
        output mode_sel, mode_load, pause,
        input  led, tick, mode_active
    );

    // Engine side.
    modport slave (
        input  mode_sel, mode_load, pause,
        output led, tick, mode_active
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled step tick driving COUNT / CHASE / BOUNCE /
// BREATHE patterns, with mode switches deferred to the next tick.
module led_pattern_engine #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned TICK_DIV = 2097152,
    parameter int unsigned PWM_BITS = 4
) (
    input logic                 CLK_12_MHZ,
    input logic                 RST_N,
    led_pattern_engine_if.slave pe
);
    localparam int unsigned PrescW = $clog2(TICK_DIV);
    localparam logic [PrescW-1:0]   PrescMax = PrescW'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] LvlMax   = '1;

    typedef enum logic [1:0] {
        ModeCount   = 2'b00,
        ModeChase   = 2'b01,
        ModeBounce  = 2'b10,
        ModeBreathe = 2'b11
    } mode_e;

    logic [PrescW-1:0]   presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] lvl_q, lvl_d;
    logic [NUM_LEDS-1:0] pat_q, pat_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    mode_e               mode_q, mode_d;
    mode_e               pend_mode_q, pend_mode_d;
    logic                pend_q, pend_d;
    // Shared by BOUNCE (pattern) and BREATHE (level); only one is live at a time.
    logic                dir_down_q, dir_down_d;
    logic                tick_w;

    assign tick_w = !pe.pause && (presc_q == PrescMax);

    // Next-state: prescaler, PWM counter, pending switch, pattern step, LED decode.
    always_comb begin
        presc_d     = presc_q;
        pwm_d       = pwm_q;
        lvl_d       = lvl_q;
        pat_d       = pat_q;
        led_d       = led_q;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        dir_down_d  = dir_down_q;

        if (!pe.pause) begin
            presc_d = tick_w ? '0 : presc_q + PrescW'(1);
            pwm_d   = pwm_q + PWM_BITS'(1);

            if (tick_w) begin
                if (pend_q) begin
                    // Switch replaces the step for this tick.
                    mode_d     = pend_mode_q;
                    pend_d     = 1'b0;
                    pat_d      = (pend_mode_q == ModeCount) ? '0 : NUM_LEDS'(1);
                    lvl_d      = '0;
                    dir_down_d = 1'b0;
                end else begin
                    unique case (mode_q)
                        ModeCount: pat_d = pat_q + NUM_LEDS'(1);
                        ModeChase: pat_d = (pat_q << 1) | (pat_q >> (NUM_LEDS - 1));
                        ModeBounce: begin
                            if (NUM_LEDS > 1) begin
                                pat_d = dir_down_q ? (pat_q >> 1) : (pat_q << 1);
                                // Turn around as soon as an end is lit.
                                if (pat_d[NUM_LEDS-1]) begin
                                    dir_down_d = 1'b1;
                                end else if (pat_d[0]) begin
                                    dir_down_d = 1'b0;
                                end
                            end
                        end
                        ModeBreathe: begin
                            lvl_d = dir_down_q ? (lvl_q - PWM_BITS'(1))
                                               : (lvl_q + PWM_BITS'(1));
                            if (lvl_d == LvlMax) begin
                                dir_down_d = 1'b1;
                            end else if (lvl_d == '0) begin
                                dir_down_d = 1'b0;
                            end
                        end
                        default: pat_d = pat_q;
                    endcase
                end
            end

            // A load in the tick cycle lands after the tick's switch/step.
            if (pe.mode_load) begin
                pend_d      = 1'b1;
                pend_mode_d = mode_e'(pe.mode_sel);
            end

            // Decode from next state so a step shows on led the cycle after tick.
            if (mode_d == ModeBreathe) begin
                led_d = {NUM_LEDS{pwm_d < lvl_d}};
            end else begin
                led_d = pat_d;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
        if (!RST_N) begin
            presc_q     <= '0;
            pwm_q       <= '0;
            lvl_q       <= '0;
            pat_q       <= '0;
            led_q       <= '0;
            mode_q      <= ModeCount;
            pend_mode_q <= ModeCount;
            pend_q      <= 1'b0;
            dir_down_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            pwm_q       <= pwm_d;
            lvl_q       <= lvl_d;
            pat_q       <= pat_d;
            led_q       <= led_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            dir_down_q  <= dir_down_d;
        end
    end

    assign pe.led         = led_q;
    assign pe.tick        = tick_w;
    assign pe.mode_active = mode_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Randomized self-checking bench for led_pattern_engine against a step-index
// reference model (patterns computed as closed-form functions of step count).
module tb_led_pattern_engine;
    localparam int unsigned NL = 4;
    localparam int unsigned TD = 4;
    localparam int unsigned PB = 2;
    localparam int unsigned LVL_MAX = (1 << PB) - 1;

    logic clk;
    logic rst_n;

    led_pattern_engine_if #(.NUM_LEDS(NL)) bus ();

    led_pattern_engine #(
        .NUM_LEDS(NL),
        .TICK_DIV(TD),
        .PWM_BITS(PB)
    ) dut (
        .CLK_12_MHZ(clk),
        .RST_N     (rst_n),
        .pe        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int m_presc;
    int m_pwm;
    int m_mode;
    int m_k;        // steps taken since the current mode started
    bit m_pend;
    int m_pend_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int tri_wave(input int k, input int top);
        int p;
        p = k % (2 * top);
        return (p <= top) ? p : 2 * top - p;
    endfunction

    function automatic logic [31:0] exp_led();
        logic [31:0] v;
        case (m_mode)
            0: v = 32'(m_k % (1 << NL));
            1: v = 32'(1) << (m_k % NL);
            2: v = 32'(1) << tri_wave(m_k, NL - 1);
            default: v = (m_pwm < tri_wave(m_k, LVL_MAX)) ? 32'((1 << NL) - 1) : 32'(0);
        endcase
        return v;
    endfunction

    function automatic void model_reset();
        m_presc = 0;
        m_pwm = 0;
        m_mode = 0;
        m_k = 0;
        m_pend = 0;
        m_pend_mode = 0;
    endfunction

    function automatic void model_edge(input bit ld, input int sel, input bit pz);
        bit t;
        if (pz) return;
        t = (m_presc == TD - 1);
        m_presc = t ? 0 : m_presc + 1;
        m_pwm = (m_pwm + 1) % (1 << PB);
        if (t) begin
            if (m_pend) begin
                m_mode = m_pend_mode;
                m_k = 0;
                m_pend = 0;
            end else begin
                m_k++;
            end
        end
        if (ld) begin
            m_pend = 1;
            m_pend_mode = sel;
        end
    endfunction

    // One clock: drive inputs, check outputs of the current state, advance.
    task automatic cycle(input bit ld, input int sel, input bit pz);
        bus.mode_load = ld;
        bus.mode_sel  = 2'(sel);
        bus.pause     = pz;
        #1;
        chk("tick", 32'(bus.tick), 32'(!pz && m_presc == TD - 1));
        chk("led", 32'(bus.led), exp_led());
        chk("mode_active", 32'(bus.mode_active), 32'(m_mode));
        @(posedge clk);
        model_edge(ld, sel, pz);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    // Mid-cycle asynchronous reset pulse; outputs must clear without a clock edge.
    task automatic reset_pulse();
        bus.mode_load = 1'b0;
        bus.pause     = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_led", 32'(bus.led), 32'(0));
        chk("rst_tick", 32'(bus.tick), 32'(0));
        chk("rst_mode", 32'(bus.mode_active), 32'(0));
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.mode_sel  = 2'b00;
        bus.mode_load = 1'b0;
        bus.pause     = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("por_led", 32'(bus.led), 32'(0));
        chk("por_mode", 32'(bus.mode_active), 32'(0));
        rst_n = 1'b1;

        // Free count through a full wrap.
        idle(70);
        // Each pattern mode.
        cycle(1'b1, 1, 1'b0); idle(24);
        cycle(1'b1, 2, 1'b0); idle(36);
        cycle(1'b1, 3, 1'b0); idle(40);
        // Pause mid-count.
        cycle(1'b1, 0, 1'b0); idle(6);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1);
        idle(10);
        // Last load wins.
        cycle(1'b1, 1, 1'b0); cycle(1'b1, 2, 1'b0); idle(10);
        // Reset with a switch pending.
        cycle(1'b1, 1, 1'b0); cycle(1'b0, 0, 1'b0);
        reset_pulse(); idle(10);
        // Load in the tick cycle itself.
        for (int i = 0; i < int'(TD) && m_presc != TD - 1; i++) cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 3, 1'b0); idle(12);
        // Reload of the already-active mode.
        cycle(1'b1, 3, 1'b0); idle(12);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit ld;
            bit pz;
            ld = ($urandom_range(0, 11) == 0);
            pz = ($urandom_range(0, 6) == 0);
            cycle(ld, int'($urandom_range(0, 3)), pz);
            if ($urandom_range(0, 599) == 0) reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
